// File: rtl/sdram_arbiter_if.sv
// rtl/sdram_arbiter_if.sv - bus bundle between two masters, the arbiter and the SDRAM controller port
interface sdram_arbiter_if;
    logic        m0_read;
    logic        m0_write;
    logic [20:0] m0_addr;
    logic [3:0]  m0_byte_en;
    logic [31:0] m0_wrdata;
    logic [31:0] m0_rddata;
    logic        m0_ready;

    logic        m1_read;
    logic        m1_write;
    logic [20:0] m1_addr;
    logic [3:0]  m1_byte_en;
    logic [31:0] m1_wrdata;
    logic [31:0] m1_rddata;
    logic        m1_ready;

    logic [21:0] ctl_addr;
    logic [1:0]  ctl_byte_en;
    logic        ctl_write;
    logic        ctl_read;
    logic [15:0] ctl_wrdata;
    logic [15:0] ctl_rddata;
    logic        ctl_wait;

    logic        grant;
    logic        busy;
    logic        err;

    // arbiter side
    modport slave (
        input  m0_read, m0_write, m0_addr, m0_byte_en, m0_wrdata,
        output m0_rddata, m0_ready,
        input  m1_read, m1_write, m1_addr, m1_byte_en, m1_wrdata,
        output m1_rddata, m1_ready,
        output ctl_addr, ctl_byte_en, ctl_write, ctl_read, ctl_wrdata,
        input  ctl_rddata, ctl_wait,
        output grant, busy, err
    );

    // masters plus controller side
    modport master (
        output m0_read, m0_write, m0_addr, m0_byte_en, m0_wrdata,
        input  m0_rddata, m0_ready,
        output m1_read, m1_write, m1_addr, m1_byte_en, m1_wrdata,
        input  m1_rddata, m1_ready,
        input  ctl_addr, ctl_byte_en, ctl_write, ctl_read, ctl_wrdata,
        output ctl_rddata, ctl_wait,
        input  grant, busy, err
    );
endinterface

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - round-robin two-master arbiter splitting 32-bit words into 16-bit controller accesses
module sdram_arbiter #(
    parameter int TIMEOUT_CYC = 1023,
    parameter int CW          = 10
) (
    input  logic            sys_clk,
    input  logic            rst,
    sdram_arbiter_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE_LO, S_WAIT_LO, S_ISSUE_HI, S_WAIT_HI, S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic          grant_q, last_q, op_wr;
    logic [20:0]   addr_q;
    logic [3:0]    be_q;
    logic [31:0]   wdata_q, res_q, hold0, hold1;
    logic [CW-1:0] to_cnt;
    logic          err_q;

    logic          req0, req1, win, win_wr;
    logic [3:0]    win_be;
    logic          lo_phase, hi_phase, in_wait;

    assign lo_phase = (state == S_ISSUE_LO) || (state == S_WAIT_LO);
    assign hi_phase = (state == S_ISSUE_HI) || (state == S_WAIT_HI);
    assign in_wait  = (state == S_WAIT_LO) || (state == S_WAIT_HI);

    // request decode: a tie goes to the master that did not win last time
    always_comb begin
        req0   = bus.m0_read | bus.m0_write;
        req1   = bus.m1_read | bus.m1_write;
        win    = (req0 && req1) ? ~last_q : req1;
        win_wr = win ? bus.m1_write : bus.m0_write;
        win_be = win ? bus.m1_byte_en : bus.m0_byte_en;
    end

    // state register
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // next-state: write halves with no enabled bytes are skipped entirely
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req0 || req1) begin
                    if (!win_wr || (win_be[1:0] != 2'b00)) state_nxt = S_ISSUE_LO;
                    else if (win_be[3:2] != 2'b00)         state_nxt = S_ISSUE_HI;
                    else                                    state_nxt = S_DONE;
                end
            end
            S_ISSUE_LO: state_nxt = S_WAIT_LO;
            S_WAIT_LO: begin
                if (!bus.ctl_wait)
                    state_nxt = (!op_wr || (be_q[3:2] != 2'b00)) ? S_ISSUE_HI : S_DONE;
            end
            S_ISSUE_HI: state_nxt = S_WAIT_HI;
            S_WAIT_HI: begin
                if (!bus.ctl_wait) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // grant latch, result assembly and per-master read-data hold
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            op_wr   <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            res_q   <= '0;
            hold0   <= '0;
            hold1   <= '0;
        end else begin
            if ((state == S_IDLE) && (req0 || req1)) begin
                grant_q <= win;
                last_q  <= win;
                op_wr   <= win_wr;
                addr_q  <= win ? bus.m1_addr : bus.m0_addr;
                be_q    <= win_be;
                wdata_q <= win ? bus.m1_wrdata : bus.m0_wrdata;
            end
            if ((state == S_WAIT_LO) && !bus.ctl_wait) res_q[15:0]  <= bus.ctl_rddata;
            if ((state == S_WAIT_HI) && !bus.ctl_wait) res_q[31:16] <= bus.ctl_rddata;
            if (state == S_DONE) begin
                if (grant_q) hold1 <= res_q;
                else         hold0 <= res_q;
            end
        end
    end

    // completion watchdog: flags a stuck controller but keeps waiting on it
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if ((state == S_ISSUE_LO) || (state == S_ISSUE_HI))
                to_cnt <= '0;
            else if (in_wait && (to_cnt != CW'(TIMEOUT_CYC)))
                to_cnt <= to_cnt + CW'(1);
            if (in_wait && (to_cnt == CW'(TIMEOUT_CYC)))
                err_q <= 1'b1;
        end
    end

    // outputs: controller fields are held for the whole issue/wait window of a half
    always_comb begin
        bus.ctl_read    = 1'b0;
        bus.ctl_write   = 1'b0;
        bus.ctl_addr    = '0;
        bus.ctl_byte_en = 2'b00;
        bus.ctl_wrdata  = '0;
        if ((state == S_ISSUE_LO) || (state == S_ISSUE_HI)) begin
            bus.ctl_read  = ~op_wr;
            bus.ctl_write = op_wr;
        end
        if (lo_phase) begin
            bus.ctl_addr    = {addr_q, 1'b0};
            bus.ctl_byte_en = op_wr ? be_q[1:0] : 2'b11;
            bus.ctl_wrdata  = op_wr ? wdata_q[15:0] : 16'h0000;
        end else if (hi_phase) begin
            bus.ctl_addr    = {addr_q, 1'b1};
            bus.ctl_byte_en = op_wr ? be_q[3:2] : 2'b11;
            bus.ctl_wrdata  = op_wr ? wdata_q[31:16] : 16'h0000;
        end
        bus.m0_ready  = (state == S_DONE) && !grant_q;
        bus.m1_ready  = (state == S_DONE) && grant_q;
        bus.m0_rddata = bus.m0_ready ? res_q : hold0;
        bus.m1_rddata = bus.m1_ready ? res_q : hold1;
        bus.grant     = grant_q;
        bus.busy      = (state != S_IDLE);
        bus.err       = err_q;
    end
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - scoreboard bench for sdram_arbiter with a behavioural controller
module tb_sdram_arbiter;
    localparam int CTL_LAT = 8;

    typedef struct packed {
        logic        wr;
        logic [21:0] addr;
        logic [1:0]  be;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } ctl_t;

    typedef struct packed {
        logic        m;
        logic        rd;
        logic [31:0] data;
    } done_t;

    logic sys_clk = 1'b0;
    logic rst = 1'b0;
    always #10 sys_clk = ~sys_clk;

    sdram_arbiter_if bus();

    sdram_arbiter #(.TIMEOUT_CYC(1023), .CW(10)) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus.slave)
    );

    ctl_t  exp_ctl[$];
    done_t exp_done[$];
    int    n_tests = 0;
    int    n_fail = 0;
    int    done_cnt = 0;
    int    strobe_cnt = 0;
    int    issued0 = 0, issued1 = 0, done0 = 0, done1 = 0;
    logic  rd0 = 0, wr0 = 0, rd1 = 0, wr1 = 0;
    logic  hang = 0;
    logic [31:0] trk0 = 0, trk1 = 0;
    logic  trkv0 = 1, trkv1 = 1;

    assign bus.m0_read  = rd0 && (issued0 != done0);
    assign bus.m0_write = wr0 && (issued0 != done0);
    assign bus.m1_read  = rd1 && (issued1 != done1);
    assign bus.m1_write = wr1 && (issued1 != done1);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_ctl(input logic wr, input logic [21:0] a, input logic [1:0] be,
                            input logic [15:0] wd, input logic [15:0] rd);
        ctl_t e;
        e.wr = wr; e.addr = a; e.be = be; e.wdata = wd; e.rdata = rd;
        exp_ctl.push_back(e);
    endtask

    task automatic push_done(input logic m, input logic rd, input logic [31:0] d);
        done_t e;
        e.m = m; e.rd = rd; e.data = d;
        exp_done.push_back(e);
    endtask

    task automatic req(input int m, input logic rd, input logic wr, input logic [20:0] a,
                       input logic [3:0] be, input logic [31:0] d, input int n);
        if (m == 0) begin
            bus.m0_addr = a; bus.m0_byte_en = be; bus.m0_wrdata = d;
            rd0 = rd; wr0 = wr; issued0 = done0 + n;
        end else begin
            bus.m1_addr = a; bus.m1_byte_en = be; bus.m1_wrdata = d;
            rd1 = rd; wr1 = wr; issued1 = done1 + n;
        end
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        int i = 0;
        while (done_cnt < target && i < budget) begin
            @(negedge sys_clk); #1; i++;
        end
        chk(tag, 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic wait_strobes(input int target, input int budget, input string tag);
        int i = 0;
        while (strobe_cnt < target && i < budget) begin
            @(negedge sys_clk); #1; i++;
        end
        chk(tag, 32'(strobe_cnt >= target), 32'd1);
    endtask

    task automatic cancel_reqs();
        issued0 = done0; issued1 = done1;
        rd0 = 0; wr0 = 0; rd1 = 0; wr1 = 0;
    endtask

    // controller model: fixed completion latency, or never completes while hang is set
    initial begin : ctl_model
        ctl_t e;
        logic pending;
        int   lat;
        pending = 0;
        lat = 0;
        e = '0;
        bus.ctl_wait = 1'b1;
        bus.ctl_rddata = 16'h0000;
        forever begin
            @(negedge sys_clk);
            bus.ctl_wait = 1'b1;
            if (rst) begin
                pending = 0;
            end else if (pending) begin
                chk("strobe_in_wait", 32'(bus.ctl_read | bus.ctl_write), 32'd0);
                if (!hang) lat++;
                if (lat >= CTL_LAT) begin
                    chk("hold_addr", 32'(bus.ctl_addr), 32'(e.addr));
                    chk("hold_be", 32'(bus.ctl_byte_en), 32'(e.be));
                    if (e.wr) chk("hold_wrdata", 32'(bus.ctl_wrdata), 32'(e.wdata));
                    bus.ctl_rddata = e.rdata;
                    bus.ctl_wait = 1'b0;
                    pending = 0;
                end
            end else if (bus.ctl_read || bus.ctl_write) begin
                strobe_cnt++;
                chk("ctl_expected", 32'(exp_ctl.size() != 0), 32'd1);
                if (exp_ctl.size() != 0) begin
                    e = exp_ctl.pop_front();
                    chk("ctl_write", 32'(bus.ctl_write), 32'(e.wr));
                    chk("ctl_read", 32'(bus.ctl_read), 32'(!e.wr));
                    chk("ctl_addr", 32'(bus.ctl_addr), 32'(e.addr));
                    chk("ctl_byte_en", 32'(bus.ctl_byte_en), 32'(e.be));
                    if (e.wr) chk("ctl_wrdata", 32'(bus.ctl_wrdata), 32'(e.wdata));
                    pending = 1;
                    lat = 0;
                end
            end
        end
    end

    // completion monitor: pops the expected-completion queue on every ready pulse
    initial begin : rdy_mon
        done_t d;
        logic  p0, p1;
        p0 = 0; p1 = 0;
        forever begin
            @(negedge sys_clk);
            if (!rst && (bus.m0_ready || bus.m1_ready)) begin
                chk("ready_both", 32'(bus.m0_ready & bus.m1_ready), 32'd0);
                chk("ready_width", 32'((p0 & bus.m0_ready) | (p1 & bus.m1_ready)), 32'd0);
                chk("ready_expected", 32'(exp_done.size() != 0), 32'd1);
                if (exp_done.size() != 0) begin
                    d = exp_done.pop_front();
                    chk("ready_master", 32'(bus.m1_ready), 32'(d.m));
                    chk("grant", 32'(bus.grant), 32'(d.m));
                    if (bus.m1_ready) begin
                        if (d.rd) chk("m1_rddata", bus.m1_rddata, d.data);
                        if (trkv0) chk("m0_rddata_hold", bus.m0_rddata, trk0);
                        trk1 = d.data; trkv1 = d.rd;
                    end else begin
                        if (d.rd) chk("m0_rddata", bus.m0_rddata, d.data);
                        if (trkv1) chk("m1_rddata_hold", bus.m1_rddata, trk1);
                        trk0 = d.data; trkv0 = d.rd;
                    end
                end
                if (bus.m0_ready) done0++;
                if (bus.m1_ready) done1++;
                done_cnt++;
            end
            p0 = bus.m0_ready;
            p1 = bus.m1_ready;
        end
    end

    initial begin : stim
        int base;
        bus.m0_addr = '0; bus.m0_byte_en = '0; bus.m0_wrdata = '0;
        bus.m1_addr = '0; bus.m1_byte_en = '0; bus.m1_wrdata = '0;
        #1 rst = 1'b1;
        #4;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_ready", 32'({bus.m0_ready, bus.m1_ready}), 32'd0);
        chk("rst_strobes", 32'({bus.ctl_read, bus.ctl_write}), 32'd0);
        chk("rst_ctl_addr", 32'(bus.ctl_addr), 32'd0);
        chk("rst_ctl_be", 32'(bus.ctl_byte_en), 32'd0);
        chk("rst_ctl_wrdata", 32'(bus.ctl_wrdata), 32'd0);
        chk("rst_m0_rddata", bus.m0_rddata, 32'd0);
        chk("rst_m1_rddata", bus.m1_rddata, 32'd0);
        @(negedge sys_clk); @(negedge sys_clk); #1 rst = 1'b0;

        // both masters read continuously: grants alternate 0,1,0,1
        for (int k = 0; k < 2; k++) begin
            push_ctl(0, {21'h00100, 1'b0}, 2'b11, 16'h0, 16'h1111);
            push_ctl(0, {21'h00100, 1'b1}, 2'b11, 16'h0, 16'h2222);
            push_ctl(0, {21'h00200, 1'b0}, 2'b11, 16'h0, 16'h3333);
            push_ctl(0, {21'h00200, 1'b1}, 2'b11, 16'h0, 16'h4444);
            push_done(0, 1, 32'h22221111);
            push_done(1, 1, 32'h44443333);
        end
        base = done_cnt;
        req(0, 1, 0, 21'h00100, 4'h0, 32'h0, 2);
        req(1, 1, 0, 21'h00200, 4'h0, 32'h0, 2);
        wait_done(base + 4, 400, "rr_done");

        // full-word write from m0
        push_ctl(1, {21'h00010, 1'b0}, 2'b11, 16'hBEEF, 16'h0);
        push_ctl(1, {21'h00010, 1'b1}, 2'b11, 16'hDEAD, 16'h0);
        push_done(0, 0, 32'h0);
        base = done_cnt;
        req(0, 0, 1, 21'h00010, 4'hF, 32'hDEADBEEF, 1);
        wait_done(base + 1, 100, "wr_done");

        // read at the top word address from m1
        push_ctl(0, 22'h3FFFFE, 2'b11, 16'h0, 16'h1234);
        push_ctl(0, 22'h3FFFFF, 2'b11, 16'h0, 16'hABCD);
        push_done(1, 1, 32'hABCD1234);
        base = done_cnt;
        req(1, 1, 0, 21'h1FFFFF, 4'h0, 32'h0, 1);
        wait_done(base + 1, 100, "rd_done");

        // byte-enable skipping
        push_ctl(1, {21'h00055, 1'b1}, 2'b11, 16'h1234, 16'h0);
        push_done(0, 0, 32'h0);
        base = done_cnt;
        req(0, 0, 1, 21'h00055, 4'hC, 32'h12345678, 1);
        wait_done(base + 1, 60, "be_c_done");

        push_ctl(1, {21'h00055, 1'b0}, 2'b10, 16'hF00D, 16'h0);
        push_done(0, 0, 32'h0);
        base = done_cnt;
        req(0, 0, 1, 21'h00055, 4'h2, 32'hCAFEF00D, 1);
        wait_done(base + 1, 60, "be_2_done");

        push_done(0, 0, 32'h0);
        base = strobe_cnt;
        req(0, 0, 1, 21'h00055, 4'h0, 32'h11111111, 1);
        wait_done(done_cnt + 1, 3, "be_0_latency");
        chk("be_0_no_strobe", 32'(strobe_cnt), 32'(base));

        // read and write together on one master is a write
        push_ctl(1, {21'h00077, 1'b0}, 2'b11, 16'hF00D, 16'h0);
        push_done(1, 0, 32'h0);
        base = done_cnt;
        req(1, 1, 1, 21'h00077, 4'h3, 32'h0BADF00D, 1);
        wait_done(base + 1, 60, "rdwr_done");

        // reset during the high-half wait of a write
        push_ctl(1, {21'h00020, 1'b0}, 2'b11, 16'h33CC, 16'h0);
        push_ctl(1, {21'h00020, 1'b1}, 2'b11, 16'h55AA, 16'h0);
        base = strobe_cnt;
        req(0, 0, 1, 21'h00020, 4'hF, 32'h55AA33CC, 1);
        wait_strobes(base + 2, 60, "mid_hi_strobe");
        @(negedge sys_clk); @(negedge sys_clk); #1;
        rst = 1'b1;
        cancel_reqs();
        #1;
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_strobes", 32'({bus.ctl_read, bus.ctl_write}), 32'd0);
        chk("mid_rst_ctl_addr", 32'(bus.ctl_addr), 32'd0);
        chk("mid_rst_grant", 32'(bus.grant), 32'd0);
        chk("mid_rst_ready", 32'({bus.m0_ready, bus.m1_ready}), 32'd0);
        trk0 = 0; trk1 = 0; trkv0 = 1; trkv1 = 1;
        @(negedge sys_clk); #1 rst = 1'b0;
        chk("mid_rst_ctl_queue", 32'(exp_ctl.size()), 32'd0);

        push_ctl(0, {21'h00033, 1'b0}, 2'b11, 16'h0, 16'h0001);
        push_ctl(0, {21'h00033, 1'b1}, 2'b11, 16'h0, 16'h0002);
        push_done(1, 1, 32'h00020001);
        base = done_cnt;
        req(1, 1, 0, 21'h00033, 4'h0, 32'h0, 1);
        wait_done(base + 1, 100, "post_rst_m1");

        // controller never completes: err rises and is sticky until reset
        hang = 1;
        push_ctl(0, {21'h00040, 1'b0}, 2'b11, 16'h0, 16'h0);
        base = strobe_cnt;
        req(0, 1, 0, 21'h00040, 4'h0, 32'h0, 1);
        wait_strobes(base + 1, 10, "to_strobe");
        repeat (1020) @(negedge sys_clk);
        #1 chk("to_err_early", 32'(bus.err), 32'd0);
        repeat (10) @(negedge sys_clk);
        #1 chk("to_err_set", 32'(bus.err), 32'd1);
        repeat (20) @(negedge sys_clk);
        #1 chk("to_err_sticky", 32'(bus.err), 32'd1);
        chk("to_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        cancel_reqs();
        #1;
        chk("to_rst_err", 32'(bus.err), 32'd0);
        chk("to_rst_busy", 32'(bus.busy), 32'd0);
        chk("to_rst_strobes", 32'({bus.ctl_read, bus.ctl_write}), 32'd0);
        hang = 0;
        trk0 = 0; trk1 = 0; trkv0 = 1; trkv1 = 1;
        @(negedge sys_clk); #1 rst = 1'b0;

        // recovery read after the timeout reset
        push_ctl(0, {21'h00040, 1'b0}, 2'b11, 16'h0, 16'h5555);
        push_ctl(0, {21'h00040, 1'b1}, 2'b11, 16'h0, 16'h6666);
        push_done(0, 1, 32'h66665555);
        base = done_cnt;
        req(0, 1, 0, 21'h00040, 4'h0, 32'h0, 1);
        wait_done(base + 1, 100, "recover_done");

        repeat (4) @(negedge sys_clk);
        #1;
        chk("ctl_queue_empty", 32'(exp_ctl.size()), 32'd0);
        chk("done_queue_empty", 32'(exp_done.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
